// File: rtl/bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
// State and grant encodings are common to the top and the bench.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS_INSTR,
    BUS_DATA,
    RESP
  } state_t;

  typedef enum logic {
    GRANT_INSTR,
    GRANT_DATA
  } grant_t;

  localparam logic BUS_OP_READ  = 1'b0;
  localparam logic BUS_OP_WRITE = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and external-bus signals of the memory bus arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);

  logic                    instr_read_in;
  logic [ADDR_WIDTH-1:0]   instr_address_in;
  logic                    instr_ready_out;
  logic                    instr_fault_out;
  logic [DATA_WIDTH-1:0]   instr_read_value_out;

  logic                    data_read_in;
  logic                    data_write_in;
  logic [ADDR_WIDTH-1:0]   data_address_in;
  logic [DATA_WIDTH-1:0]   data_write_value_in;
  logic [DATA_WIDTH/8-1:0] data_write_mask_in;
  logic                    data_ready_out;
  logic                    data_fault_out;
  logic [DATA_WIDTH-1:0]   data_read_value_out;

  logic [ADDR_WIDTH-1:0]   bus_address_out;
  logic                    bus_read_out;
  logic                    bus_write_out;
  logic [DATA_WIDTH-1:0]   bus_write_value_out;
  logic [DATA_WIDTH/8-1:0] bus_write_mask_out;
  logic                    bus_ready_in;
  logic [DATA_WIDTH-1:0]   bus_read_value_in;

  modport master (
    input  instr_read_in, instr_address_in,
    input  data_read_in, data_write_in, data_address_in,
    input  data_write_value_in, data_write_mask_in,
    input  bus_ready_in, bus_read_value_in,
    output instr_ready_out, instr_fault_out, instr_read_value_out,
    output data_ready_out, data_fault_out, data_read_value_out,
    output bus_address_out, bus_read_out, bus_write_out,
    output bus_write_value_out, bus_write_mask_out
  );

  modport slave (
    output instr_read_in, instr_address_in,
    output data_read_in, data_write_in, data_address_in,
    output data_write_value_in, data_write_mask_in,
    output bus_ready_in, bus_read_value_in,
    input  instr_ready_out, instr_fault_out, instr_read_value_out,
    input  data_ready_out, data_fault_out, data_read_value_out,
    input  bus_address_out, bus_read_out, bus_write_out,
    input  bus_write_value_out, bus_write_mask_out
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// Bus-ready watchdog: counts unanswered strobe cycles and flags the last allowed one.
// A zero limit removes the counter entirely and never expires.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] r_count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_count <= '0;
        end else if (i_clear) begin
          r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
          r_count <= r_count + CW'(1);
        end
      end

      // The cycle that would push the count to the limit is the expiry cycle.
      assign o_expire = i_enable && (r_count == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one external memory bus between fetch and data ports.
// One transaction at a time; all bus-side and response outputs are registered.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int          ADDR_WIDTH     = 64,
  parameter int          DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic reset,
  mem_bus_arbiter_if.master bus_if
);

  state_t                  r_state;
  grant_t                  r_last_grant;
  logic                    r_bus_read;
  logic                    r_bus_write;
  logic [ADDR_WIDTH-1:0]   r_bus_addr;
  logic [DATA_WIDTH-1:0]   r_bus_wval;
  logic [DATA_WIDTH/8-1:0] r_bus_mask;
  logic                    r_instr_ready;
  logic                    r_instr_fault;
  logic [DATA_WIDTH-1:0]   r_instr_val;
  logic                    r_data_ready;
  logic                    r_data_fault;
  logic [DATA_WIDTH-1:0]   r_data_val;

  logic w_instr_req;
  logic w_data_req;
  logic w_grant_data;
  logic w_data_op;
  logic w_bus_busy;
  logic w_done;
  logic w_expire;

  assign w_instr_req  = bus_if.instr_read_in;
  assign w_data_req   = bus_if.data_read_in | bus_if.data_write_in;
  assign w_grant_data = w_data_req && (!w_instr_req || (r_last_grant == GRANT_INSTR));
  // A simultaneous read and write is treated as a write.
  assign w_data_op    = bus_if.data_write_in ? BUS_OP_WRITE : BUS_OP_READ;
  assign w_bus_busy   = (r_state == BUS_INSTR) || (r_state == BUS_DATA);
  assign w_done       = bus_if.bus_ready_in || w_expire;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (reset),
    .i_clear (r_state == IDLE),
    .i_enable(w_bus_busy && !bus_if.bus_ready_in),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_last_grant  <= GRANT_INSTR;
      r_bus_read    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_wval    <= '0;
      r_bus_mask    <= '0;
      r_instr_ready <= 1'b0;
      r_instr_fault <= 1'b0;
      r_instr_val   <= '0;
      r_data_ready  <= 1'b0;
      r_data_fault  <= 1'b0;
      r_data_val    <= '0;
    end else begin
      r_instr_ready <= 1'b0;
      r_data_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_data) begin
            r_bus_addr   <= bus_if.data_address_in;
            r_bus_wval   <= bus_if.data_write_value_in;
            r_bus_mask   <= bus_if.data_write_mask_in;
            r_bus_write  <= (w_data_op == BUS_OP_WRITE);
            r_bus_read   <= (w_data_op == BUS_OP_READ);
            r_last_grant <= GRANT_DATA;
            r_state      <= BUS_DATA;
          end else if (w_instr_req) begin
            r_bus_addr   <= bus_if.instr_address_in;
            r_bus_wval   <= '0;
            r_bus_mask   <= '0;
            r_bus_write  <= 1'b0;
            r_bus_read   <= 1'b1;
            r_last_grant <= GRANT_INSTR;
            r_state      <= BUS_INSTR;
          end
        end
        BUS_INSTR, BUS_DATA: begin
          if (w_done) begin
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_state     <= RESP;
            // Response is loaded on the way into RESP so it is visible during RESP.
            if (r_state == BUS_DATA) begin
              r_data_ready <= 1'b1;
              r_data_fault <= !bus_if.bus_ready_in;
              r_data_val   <= (bus_if.bus_ready_in && !r_bus_write) ?
                              bus_if.bus_read_value_in : '0;
            end else begin
              r_instr_ready <= 1'b1;
              r_instr_fault <= !bus_if.bus_ready_in;
              r_instr_val   <= bus_if.bus_ready_in ? bus_if.bus_read_value_in : '0;
            end
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_if.bus_address_out      = r_bus_addr;
  assign bus_if.bus_read_out         = r_bus_read;
  assign bus_if.bus_write_out        = r_bus_write;
  assign bus_if.bus_write_value_out  = r_bus_wval;
  assign bus_if.bus_write_mask_out   = r_bus_mask;
  assign bus_if.instr_ready_out      = r_instr_ready;
  assign bus_if.instr_fault_out      = r_instr_fault;
  assign bus_if.instr_read_value_out = r_instr_val;
  assign bus_if.data_ready_out       = r_data_ready;
  assign bus_if.data_fault_out       = r_data_fault;
  assign bus_if.data_read_value_out  = r_data_val;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 4-cycle watchdog.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_mem_bus_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_bus_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset                   = 1'b1;
    bif.instr_read_in       = 1'b0;
    bif.instr_address_in    = '0;
    bif.data_read_in        = 1'b0;
    bif.data_write_in       = 1'b0;
    bif.data_address_in     = '0;
    bif.data_write_value_in = '0;
    bif.data_write_mask_in  = '0;
    bif.bus_ready_in        = 1'b0;
    bif.bus_read_value_in   = '0;

    // Reset values
    step();
    step();
    chk("rst_bus_read",   bif.bus_read_out, 0);
    chk("rst_bus_write",  bif.bus_write_out, 0);
    chk("rst_bus_addr",   bif.bus_address_out, 0);
    chk("rst_instr_rdy",  bif.instr_ready_out, 0);
    chk("rst_data_rdy",   bif.data_ready_out, 0);
    chk("rst_data_val",   bif.data_read_value_out, 0);
    reset = 1'b0;

    // Lone fetch, bus answers on the first strobe cycle
    bif.instr_read_in    = 1'b1;
    bif.instr_address_in = 64'h1000;
    step();
    chk("fetch_strobe_c1", bif.bus_read_out, 1);
    chk("fetch_addr_c1",   bif.bus_address_out, 64'h1000);
    chk("fetch_rdy_c1",    bif.instr_ready_out, 0);
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'hDEADBEEF;
    step();
    bif.bus_ready_in      = 1'b0;
    bif.bus_read_value_in = '0;
    chk("fetch_rdy_c2",    bif.instr_ready_out, 1);
    chk("fetch_val_c2",    bif.instr_read_value_out, 64'hDEADBEEF);
    chk("fetch_fault_c2",  bif.instr_fault_out, 0);
    chk("fetch_strobe_c2", bif.bus_read_out, 0);
    chk("fetch_drdy_c2",   bif.data_ready_out, 0);
    bif.instr_read_in = 1'b0;
    step();
    chk("fetch_rdy_c3",  bif.instr_ready_out, 0);
    chk("fetch_hold_c3", bif.instr_read_value_out, 64'hDEADBEEF);

    // Contention with both held: grants go D, I, D, I
    bif.instr_read_in    = 1'b1;
    bif.instr_address_in = 64'h100;
    bif.data_read_in     = 1'b1;
    bif.data_address_in  = 64'h200;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_addr",   bif.bus_address_out, (k % 2 == 0) ? 64'h200 : 64'h100);
      chk("rr_strobe", bif.bus_read_out, 1);
      bif.bus_ready_in      = 1'b1;
      bif.bus_read_value_in = 64'h1000 + 64'(k);
      step();
      bif.bus_ready_in = 1'b0;
      if (k % 2 == 0) begin
        chk("rr_data_rdy",  bif.data_ready_out, 1);
        chk("rr_instr_idle", bif.instr_ready_out, 0);
        chk("rr_data_val",  bif.data_read_value_out, 64'h1000 + 64'(k));
      end else begin
        chk("rr_instr_rdy", bif.instr_ready_out, 1);
        chk("rr_data_idle", bif.data_ready_out, 0);
        chk("rr_instr_val", bif.instr_read_value_out, 64'h1000 + 64'(k));
      end
      step();
      chk("rr_idle_strobe", bif.bus_read_out, 0);
    end
    bif.instr_read_in = 1'b0;
    bif.data_read_in  = 1'b0;
    step();
    chk("rr_no_grant", bif.bus_read_out, 0);

    // Store held through a 4-cycle ready wait; ready lands on the expiry cycle
    bif.data_write_in       = 1'b1;
    bif.data_address_in     = 64'h2008;
    bif.data_write_value_in = 64'h55;
    bif.data_write_mask_in  = 8'h0F;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk("st_write", bif.bus_write_out, 1);
      chk("st_read",  bif.bus_read_out, 0);
      chk("st_addr",  bif.bus_address_out, 64'h2008);
      chk("st_wval",  bif.bus_write_value_out, 64'h55);
      chk("st_mask",  bif.bus_write_mask_out, 8'h0F);
      chk("st_rdy_wait", bif.data_ready_out, 0);
      if (c < 4) step();
    end
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'hABCD;
    step();
    bif.bus_ready_in  = 1'b0;
    bif.data_write_in = 1'b0;
    chk("st_rdy",    bif.data_ready_out, 1);
    chk("st_fault",  bif.data_fault_out, 0);
    chk("st_val",    bif.data_read_value_out, 0);
    chk("st_wr_off", bif.bus_write_out, 0);
    step();
    chk("st_rdy_once", bif.data_ready_out, 0);

    // Timeout: no bus ready at all
    bif.data_read_in      = 1'b1;
    bif.data_address_in   = 64'h3000;
    bif.bus_read_value_in = 64'hFFFF;
    step();
    for (int c = 1; c <= 4; c++) begin
      chk("to_strobe", bif.bus_read_out, 1);
      chk("to_no_rdy", bif.data_ready_out, 0);
      step();
    end
    bif.data_read_in = 1'b0;
    chk("to_strobe_drop", bif.bus_read_out, 0);
    chk("to_rdy",         bif.data_ready_out, 1);
    chk("to_fault",       bif.data_fault_out, 1);
    chk("to_val",         bif.data_read_value_out, 0);
    step();
    chk("to_rdy_once", bif.data_ready_out, 0);

    // Ready arriving on the expiry cycle wins
    bif.data_read_in    = 1'b1;
    bif.data_address_in = 64'h3008;
    step();
    step();
    step();
    step();
    chk("tr_strobe_c4", bif.bus_read_out, 1);
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'h77;
    step();
    bif.bus_ready_in = 1'b0;
    bif.data_read_in = 1'b0;
    chk("tr_rdy",   bif.data_ready_out, 1);
    chk("tr_fault", bif.data_fault_out, 0);
    chk("tr_val",   bif.data_read_value_out, 64'h77);
    step();

    // Read and write together: write wins
    bif.data_read_in        = 1'b1;
    bif.data_write_in       = 1'b1;
    bif.data_address_in     = 64'h4000;
    bif.data_write_value_in = 64'h99;
    bif.data_write_mask_in  = 8'hFF;
    step();
    chk("ill_write", bif.bus_write_out, 1);
    chk("ill_read",  bif.bus_read_out, 0);
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'h1234;
    step();
    bif.bus_ready_in  = 1'b0;
    bif.data_read_in  = 1'b0;
    bif.data_write_in = 1'b0;
    chk("ill_rdy", bif.data_ready_out, 1);
    chk("ill_val", bif.data_read_value_out, 0);
    step();

    // Fetch withdrawn mid-wait still completes
    bif.instr_read_in    = 1'b1;
    bif.instr_address_in = 64'h5000;
    step();
    chk("fl_strobe_c1", bif.bus_read_out, 1);
    bif.instr_read_in = 1'b0;
    step();
    chk("fl_strobe_c2", bif.bus_read_out, 1);
    chk("fl_addr_c2",   bif.bus_address_out, 64'h5000);
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'h5A;
    step();
    bif.bus_ready_in = 1'b0;
    chk("fl_rdy", bif.instr_ready_out, 1);
    chk("fl_val", bif.instr_read_value_out, 64'h5A);
    step();
    chk("fl_rdy_once", bif.instr_ready_out, 0);

    // Reset during BUS_DATA
    bif.data_read_in    = 1'b1;
    bif.data_address_in = 64'h6000;
    step();
    chk("rb_strobe", bif.bus_read_out, 1);
    reset = 1'b1;
    #1;
    chk("rb_strobe_now", bif.bus_read_out, 0);
    chk("rb_addr_now",   bif.bus_address_out, 0);
    chk("rb_rdy_now",    bif.data_ready_out, 0);
    bif.bus_ready_in = 1'b1;
    step();
    bif.bus_ready_in = 1'b0;
    chk("rb_no_rdy", bif.data_ready_out, 0);
    reset                = 1'b0;
    bif.instr_read_in    = 1'b1;
    bif.instr_address_in = 64'h7100;
    bif.data_address_in  = 64'h7000;
    step();
    chk("rb_grant_data", bif.bus_address_out, 64'h7000);
    bif.bus_ready_in      = 1'b1;
    bif.bus_read_value_in = 64'h42;
    step();
    bif.bus_ready_in  = 1'b0;
    bif.instr_read_in = 1'b0;
    bif.data_read_in  = 1'b0;
    chk("rb_data_rdy", bif.data_ready_out, 1);
    chk("rb_data_val", bif.data_read_value_out, 64'h42);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
